// File: rtl/vmemem_wb_bridge.sv
// -----------------------------------------------------------------------------
// vmemem_wb_bridge
//
// Purpose: converts single Wishbone (pipelined, stall) transactions into one
// one-cycle VMERdMem/VMEWrMem strobe for the generated register banks, waits
// for the matching Done pulse and returns wb_ack_o. Only one transaction is
// ever outstanding.
//
// Optional feature macro: VMEMEM_BRIDGE_TIMEOUT_EN
//   defined   : 16-bit wait counter. If no Done has arrived TIMEOUT cycles after
//               the strobe cycle, the bridge returns wb_err_o with wb_dat_o = 0.
//   undefined : no counter, wb_err_o tied low, Done is awaited indefinitely.
//
// Ports:
//   Clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i   Wishbone request qualifiers
//   wb_adr_i, wb_dat_i    word address, write data
//   wb_ack_o, wb_err_o    one-cycle completion / timeout error
//   wb_stall_o            high whenever a request cannot be accepted
//   wb_dat_o              read data, valid with wb_ack_o
//   VMEAddr, VMEWrData    address/data latched at request accept
//   VMERdMem, VMEWrMem    one-cycle access strobes to the bank
//   VMERdData             bank read data, valid with VMERdDone
//   VMERdDone, VMEWrDone  bank completion pulses
//
// States:
//   state   | meaning
//   IDLE    | ready, wb_stall_o low, waiting for cyc & stb
//   RD_WAIT | read strobed, waiting for VMERdDone (then one ack cycle)
//   WR_WAIT | write strobed, waiting for VMEWrDone (then one ack cycle)
//   DRAIN   | master dropped cyc, swallow the pending Done silently
// -----------------------------------------------------------------------------
module vmemem_wb_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_stall_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [ADDR_W-1:0] VMEAddr,
  output logic [DATA_W-1:0] VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [DATA_W-1:0] VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state;
  logic   we_q;        // direction of the outstanding access, also used in DRAIN
  logic   resp_pend;   // ack/err cycle in progress; state leaves WAIT after it
  logic   done_match;
  logic   expired;

  // Only the Done that matches the outstanding direction counts.
  assign done_match = we_q ? VMEWrDone : VMERdDone;

`ifdef VMEMEM_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Done in the terminal cycle wins over the timeout.
  assign expired = (tmo_cnt == 16'(TIMEOUT)) && !done_match;

  // Held at zero in IDLE, so it reads 0 during the strobe cycle.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state == IDLE)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign expired  = 1'b0;
  assign wb_err_o = 1'b0;
`endif

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      resp_pend  <= 1'b0;
      wb_ack_o   <= 1'b0;
`ifdef VMEMEM_BRIDGE_TIMEOUT_EN
      wb_err_o   <= 1'b0;
`endif
      wb_stall_o <= 1'b0;
      wb_dat_o   <= '0;
      VMEAddr    <= '0;
      VMEWrData  <= '0;
      VMERdMem   <= 1'b0;
      VMEWrMem   <= 1'b0;
    end else begin
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      wb_ack_o <= 1'b0;
`ifdef VMEMEM_BRIDGE_TIMEOUT_EN
      wb_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            VMEAddr    <= wb_adr_i;
            VMEWrData  <= wb_dat_i;
            we_q       <= wb_we_i;
            wb_stall_o <= 1'b1;
            resp_pend  <= 1'b0;
            if (wb_we_i) begin
              VMEWrMem <= 1'b1;
              state    <= WR_WAIT;
            end else begin
              VMERdMem <= 1'b1;
              state    <= RD_WAIT;
            end
          end
        end

        RD_WAIT, WR_WAIT: begin
          if (resp_pend) begin
            state      <= IDLE;
            resp_pend  <= 1'b0;
            wb_stall_o <= 1'b0;
          end else if (!wb_cyc_i) begin
            // Aborted: the downstream access already happened, just let it finish.
            if (done_match || expired) begin
              state      <= IDLE;
              wb_stall_o <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (done_match) begin
            wb_ack_o  <= 1'b1;
            resp_pend <= 1'b1;
            if (state == RD_WAIT)
              wb_dat_o <= VMERdData;
          end
`ifdef VMEMEM_BRIDGE_TIMEOUT_EN
          else if (expired) begin
            wb_err_o  <= 1'b1;
            wb_dat_o  <= '0;
            resp_pend <= 1'b1;
          end
`endif
        end

        DRAIN: begin
          if (done_match || expired) begin
            state      <= IDLE;
            wb_stall_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmemem_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_vmemem_wb_bridge
//
// Scoreboard bench for vmemem_wb_bridge. The driver pushes the expected bank
// access and the expected Wishbone response into queues; a bank model and a
// response monitor pop and compare independently. The reference memory is a
// plain associative array of 16-bit bank registers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vmemem_wb_bridge;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              Clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_cyc_i = 1'b0;
  logic              wb_stb_i = 1'b0;
  logic              wb_we_i = 1'b0;
  logic [ADDR_W-1:0] wb_adr_i = '0;
  logic [DATA_W-1:0] wb_dat_i = '0;
  logic              wb_ack_o, wb_err_o, wb_stall_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [ADDR_W-1:0] VMEAddr;
  logic [DATA_W-1:0] VMEWrData;
  logic              VMERdMem, VMEWrMem;
  logic [DATA_W-1:0] VMERdData = '0;
  logic              VMERdDone = 1'b0;
  logic              VMEWrDone = 1'b0;

  vmemem_wb_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .wb_dat_o(wb_dat_o), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  always #5 Clk = ~Clk;

  typedef struct { bit err; logic [31:0] dat; } resp_t;
  typedef struct { bit we; logic [7:0] adr; logic [31:0] dat; } req_t;

  resp_t       exp_resp_q[$];
  req_t        exp_req_q[$];
  logic [15:0] ref_mem [int];
  logic [31:0] model_dat = '0;
  int          checks = 0;
  int          failures = 0;

  // Bank control, owned by the driver
  int next_lat = 0;
  bit bank_dead = 1'b0;
  int kick_cnt = 0;
  int stray_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [7:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  // ---------------------------------------------------------------- bank model
  logic [15:0] bank_mem [256];
  req_t        op;
  int          pend = 0;
  bit          hold = 1'b0;
  int          kick_seen = 0;
  int          stray_seen = 0;

  initial for (int i = 0; i < 256; i++) bank_mem[i] = 16'h0000;

  task fire(input req_t o);
    if (o.we) begin
      bank_mem[o.adr] = o.dat[15:0];
      VMEWrDone = 1'b1;
    end else begin
      VMERdData = {16'h0000, bank_mem[o.adr]};
      VMERdDone = 1'b1;
    end
  endtask

  always @(negedge Clk) begin
    req_t r;
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
    VMERdData = $urandom;
    if (!rst_n) begin
      pend = 0;
      hold = 1'b0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) fire(op);
      end
      if (hold && kick_cnt != kick_seen) begin
        hold = 1'b0;
        fire(op);
      end
      kick_seen = kick_cnt;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        VMERdDone  = 1'b1;
      end
      if (VMERdMem || VMEWrMem) begin
        if (exp_req_q.size() == 0) begin
          chk("extra_strobe", {VMERdMem, VMEWrMem}, 2'b00);
        end else begin
          r = exp_req_q.pop_front();
          chk("strobe_kind", {VMERdMem, VMEWrMem}, r.we ? 2'b01 : 2'b10);
          chk("strobe_addr", VMEAddr, r.adr);
          chk("strobe_wdata", VMEWrData, r.dat);
        end
        op.we  = VMEWrMem;
        op.adr = VMEAddr;
        op.dat = VMEWrData;
        hold = 1'b0;
        pend = 0;
        if (bank_dead)          hold = 1'b1;
        else if (next_lat == 0) fire(op);
        else                    pend = next_lat;
      end
    end
  end

  // ------------------------------------------------------------ response monitor
  always @(negedge Clk) begin
    resp_t e;
    if (rst_n && (wb_ack_o || wb_err_o)) begin
      if (exp_resp_q.size() == 0) begin
        chk("unexpected_resp", {wb_ack_o, wb_err_o}, 2'b00);
      end else begin
        e = exp_resp_q.pop_front();
        chk("resp_kind", {wb_ack_o, wb_err_o}, e.err ? 2'b01 : 2'b10);
        chk("resp_data", wb_dat_o, e.dat);
        chk("strobe_before_resp", exp_req_q.size(), 0);
      end
    end
  end

  // ------------------------------------------------------------------- driver
  task automatic push_req(input bit we, input logic [7:0] adr, input logic [31:0] dat);
    req_t r;
    r.we = we; r.adr = adr; r.dat = dat;
    exp_req_q.push_back(r);
  endtask

  task automatic issue(input bit we, input logic [7:0] adr, input logic [31:0] dat);
    chk("stall_idle_before_req", wb_stall_o, 1'b0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;
    @(negedge Clk);
    wb_stb_i = 1'b0;
  endtask

  // Runs from the strobe-cycle negedge until the response; returns cycle index.
  task automatic wait_resp(input int limit, output int n);
    bit stall_low = 1'b0;
    n = 1;
    while (!(wb_ack_o || wb_err_o) && n < limit) begin
      if (!wb_stall_o) stall_low = 1'b1;
      @(negedge Clk);
      n++;
    end
    chk("resp_in_time", n < limit, 1'b1);
    chk("stall_while_busy", stall_low, 1'b0);
    chk("stall_in_resp_cycle", wb_stall_o, 1'b1);
    wb_cyc_i = 1'b0;
    @(negedge Clk);
    chk("stall_low_after_resp", wb_stall_o, 1'b0);
  endtask

  task automatic txn(input bit we, input logic [7:0] adr, input logic [31:0] dat,
                     input int lat, input bit stray);
    resp_t e;
    int n;
    e.err = 1'b0;
    if (we) begin
      e.dat = model_dat;
      ref_mem[int'(adr)] = dat[15:0];
    end else begin
      e.dat = {16'h0000, ref_rd(adr)};
      model_dat = e.dat;
    end
    next_lat = lat;
    push_req(we, adr, dat);
    exp_resp_q.push_back(e);
    issue(we, adr, dat);
    if (stray) stray_cnt++;
    wait_resp(60, n);
    chk("ack_latency", n, lat + 2);
  endtask

  task automatic txn_dead(input logic [7:0] adr);
    resp_t e;
    int n;
    logic [31:0] d;
    d = $urandom;
    bank_dead = 1'b1;
    push_req(1'b0, adr, d);
`ifdef VMEMEM_BRIDGE_TIMEOUT_EN
    e.err = 1'b1;
    e.dat = '0;
    model_dat = '0;
    exp_resp_q.push_back(e);
    issue(1'b0, adr, d);
    wait_resp(60, n);
    chk("timeout_latency", n, TIMEOUT + 2);
`else
    begin
      bit stall_low = 1'b0;
      bit got = 1'b0;
      issue(1'b0, adr, d);
      repeat (1000) begin
        if (!wb_stall_o) stall_low = 1'b1;
        if (wb_ack_o || wb_err_o) got = 1'b1;
        @(negedge Clk);
      end
      chk("stall_held_1000", stall_low, 1'b0);
      chk("no_resp_while_dead", got, 1'b0);
      e.err = 1'b0;
      e.dat = {16'h0000, ref_rd(adr)};
      model_dat = e.dat;
      exp_resp_q.push_back(e);
      kick_cnt++;
      n = 0;
      while (!wb_ack_o && n < 10) begin
        @(negedge Clk);
        n++;
      end
      chk("ack_after_late_done", wb_ack_o, 1'b1);
      wb_cyc_i = 1'b0;
      @(negedge Clk);
      chk("stall_low_after_late_done", wb_stall_o, 1'b0);
    end
`endif
    bank_dead = 1'b0;
  endtask

  task automatic abort_wr(input logic [7:0] adr, input logic [31:0] dat);
    int n;
    ref_mem[int'(adr)] = dat[15:0];
    next_lat = 3;
    push_req(1'b1, adr, dat);
    issue(1'b1, adr, dat);
    n = 1;
    @(negedge Clk);
    wb_cyc_i = 1'b0;
    n = 2;
    while (wb_stall_o && n < 30) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_stall_release", n, 5);
    chk("abort_strobe_seen", exp_req_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge Clk);
    chk("reset_outputs_zero",
        |{wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o, VMEAddr, VMEWrData, VMERdMem, VMEWrMem}, 1'b0);
    rst_n = 1'b1;
    @(negedge Clk);

    // Basic write then read back through a 16-bit bank register
    txn(1'b1, 8'h00, 32'h1234ABCD, 3, 1'b0);
    chk("bank_r1", bank_mem[0], 16'hABCD);
    txn(1'b0, 8'h00, $urandom, 2, 1'b0);

    // Combinational bank and Done exactly on the timeout boundary
    txn(1'b1, 8'h01, 32'hCAFE0001, 0, 1'b0);
    txn(1'b0, 8'h01, $urandom, 0, 1'b0);
    txn(1'b0, 8'h00, $urandom, TIMEOUT, 1'b0);

    // Stray Done in IDLE, and a read Done during a write
    stray_cnt++;
    repeat (4) @(negedge Clk);
    txn(1'b1, 8'h03, 32'h0BAD5EED, 4, 1'b1);

    // Downstream never answers, then a live read
    txn_dead(8'h07);
    txn(1'b0, 8'h03, $urandom, 1, 1'b0);

    // Master aborts the cycle, then a read of the aborted write's register
    abort_wr(8'h04, 32'h7777BEEF);
    txn(1'b0, 8'h04, $urandom, 1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      bit we;
      we = $urandom_range(0, 1) == 1;
      txn(we, 8'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3),
          we && ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    // Asynchronous reset while waiting for a write Done
    txn(1'b1, 8'h05, 32'h5555AAAA, 1, 1'b0);
    next_lat = 6;
    d = 32'h9999EEEE;
    push_req(1'b1, 8'h05, d);
    issue(1'b1, 8'h05, d);
    @(negedge Clk);
    @(posedge Clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs_zero",
        |{wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o, VMEAddr, VMEWrData, VMERdMem, VMEWrMem}, 1'b0);
    wb_cyc_i = 1'b0;
    exp_req_q.delete();
    exp_resp_q.delete();
    model_dat = '0;
    @(negedge Clk);
    @(negedge Clk);
    rst_n = 1'b1;
    repeat (8) @(negedge Clk);
    txn(1'b0, 8'h05, $urandom, 2, 1'b0);

    repeat (3) @(negedge Clk);
    chk("resp_queue_drained", exp_resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vmemem_wb_bridge.md
Name: vmemem_wb_bridge

Overview:
Upstream stage for the generated register banks with the VMERdMem/VMEWrMem strobe interface. Accepts single Wishbone-classic (pipelined stall) transactions from the crossbar and converts each into exactly one one-cycle read or write strobe plus an address. It then waits for VMERdDone/VMEWrDone and returns ack, or err on timeout. At most one transaction is outstanding at any time.

Parameters:
ADDR_W, 8, width of wb_adr_i and VMEAddr (word address)
DATA_W, 32, data width on both sides
TIMEOUT, 255, max cycles waited for Done after the strobe cycle (1..65535)

Ports:
Clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  request strobe
wb_we_i  in  1  1=write, 0=read
wb_adr_i  in  ADDR_W  word address
wb_dat_i  in  DATA_W  write data
wb_ack_o  out  1  one-cycle completion
wb_err_o  out  1  one-cycle error (timeout)
wb_stall_o  out  1  request not accepted this cycle
wb_dat_o  out  DATA_W  read data, valid with wb_ack_o
VMEAddr  out  ADDR_W  latched address to decoder/bank
VMEWrData  out  DATA_W  latched write data
VMERdMem  out  1  one-cycle read strobe
VMEWrMem  out  1  one-cycle write strobe
VMERdData  in  DATA_W  read data, valid with VMERdDone
VMERdDone  in  1  read completion pulse
VMEWrDone  in  1  write completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, except wb_stall_o=0. Counter cleared. Registers update only on rising Clk.
- States: IDLE, RD_WAIT, WR_WAIT, DRAIN.
- IDLE: wb_stall_o=0. If wb_cyc_i & wb_stb_i at edge k:
  - latch adr/dat/we into VMEAddr/VMEWrData;
  - pulse VMERdMem or VMEWrMem high for cycle k+1 only;
  - go to RD_WAIT / WR_WAIT.
- wb_stall_o=1 in every state except IDLE, and also in the cycle the strobe is high.
- RD_WAIT: on VMERdDone sampled at edge n, capture VMERdData into wb_dat_o. Pulse wb_ack_o in cycle n+1, then go to IDLE. VMEWrDone is ignored here.
- WR_WAIT: on VMEWrDone at edge n, pulse wb_ack_o in cycle n+1, then go to IDLE. VMERdDone is ignored; wb_dat_o is unchanged.
- Done may arrive in the strobe cycle itself (combinational bank). It is still accepted.
- Done inputs in IDLE are stray and ignored: no ack, no state change.
- wb_cyc_i drops in RD_WAIT/WR_WAIT: go to DRAIN. The pending downstream access is not re-issued. DRAIN waits for the matching Done (or timeout), then returns to IDLE with no wb_ack_o/wb_err_o.
- wb_ack_o and wb_err_o are never high together and never high for more than 1 cycle.
- VMEAddr/VMEWrData hold their value until the next accepted request.
- Back-to-back: the next request can be accepted in the cycle after wb_ack_o. Minimum period is strobe + bank latency + 2.

Optional Feature:
VMEMEM_BRIDGE_TIMEOUT_EN
- Defined:
  - a 16-bit counter clears on the strobe cycle and increments each cycle in RD_WAIT/WR_WAIT/DRAIN;
  - when the counter equals TIMEOUT with no Done in that cycle, pulse wb_err_o in the next cycle (suppressed if in DRAIN), set wb_dat_o=0, and go to IDLE;
  - a Done arriving in the same cycle as the timeout wins and produces ack;
  - a Done arriving after the timeout is treated as stray.
- Undefined: no counter, no err path, and wb_err_o is tied 0. The WAIT and DRAIN states wait indefinitely.

Test Plan:
1. Write: adr=0x00, dat=0x1234ABCD into a 16-bit bank register (Done 3 cycles after strobe) -> VMEWrMem high exactly 1 cycle, VMEAddr=0x00, bank r1_o=0xABCD, wb_ack_o 1 cycle after VMEWrDone, wb_err_o=0.
2. Read after test 1 -> one VMERdMem pulse, wb_dat_o=0x0000ABCD with wb_ack_o, wb_stall_o=1 from accept until ack.
3. Timeout (macro defined, TIMEOUT=15, downstream never responds) -> wb_err_o pulses exactly once, wb_dat_o=0, state IDLE; a follow-up read of a live bank acks normally. With the macro undefined -> stall stays high for 1000 cycles.
4. Abort: drop wb_cyc_i 1 cycle after strobe, Done arrives 2 cycles later -> no wb_ack_o or wb_err_o, wb_stall_o falls after Done, the next request is served correctly.
5. Stray/mismatched Done: pulse VMERdDone in IDLE, and VMERdDone during a write -> no ack. The write acks only on VMEWrDone.
6. Reset mid-operation: assert rst_n=0 asynchronously in WR_WAIT -> all outputs 0 immediately, no ack after release, the first subsequent transaction completes normally.
